dut_alu_fifo: RTL and testbench

Parametrised successor of the single-command increment/decrement datapath. It accepts operations through a valid/ready input handshake and computes one of four arithmetic ops on DATA_W-bit operands. Results, with a carry/borrow flag, are queued in an internal output FIFO. Results are drained through a valid/ready output handshake, so upstream stimulus and downstream checking can run at independent rates.

---
 rtl/dut_alu_fifo.sv | 142 ++++++++++++++
 tb/tb_dut_alu_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_alu_fifo.sv
// dut_alu_fifo: four-op arithmetic unit (INC/DEC/ADD/SUB) feeding an output FIFO.
//
// Operations enter through a valid/ready handshake, are computed combinationally
// and written into the FIFO at the accepting edge. Results leave in acceptance
// order through a second valid/ready handshake.
//
// Optional build macro: DUT_ALU_SAT_EN selects saturating arithmetic (a carry
// clamps the result to all ones, a borrow clamps it to zero). When the macro is
// undefined, results wrap around and dflag is the raw carry/borrow.
//
// Parameters:
//   DATA_W    operand/result width (>= 2)
//   DEPTH     FIFO entries (power of two, >= 2)
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  operation valid
//   in_ready  an operation can be accepted this cycle
//   cmd       opcode: 0 INC, 1 DEC, 2 ADD, 3 SUB
//   data      operand A
//   addr      operand B (ADD/SUB only)
//   out_valid FIFO head holds a result
//   out_ready consumer takes the head this cycle
//   dout      result at the FIFO head
//   dflag     carry (INC/ADD) or borrow (DEC/SUB) of the head result
//   level     current FIFO occupancy
module dut_alu_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               cmd,
    input  logic [DATA_W-1:0]        data,
    input  logic [DATA_W-1:0]        addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        dout,
    output logic                     dflag,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] LvlFull = DEPTH[PtrW:0];

    // Each entry stores {flag, result}.
    logic [DATA_W:0]   r_mem [DEPTH];
    logic [PtrW-1:0]   r_wr;
    logic [PtrW-1:0]   r_rd;
    logic [PtrW:0]     r_level;
    // Last popped entry; shown on dout/dflag while the FIFO is empty.
    logic [DATA_W:0]   r_last;

    logic              w_push;
    logic              w_pop;
    logic [DATA_W:0]   w_a;
    logic [DATA_W:0]   w_b;
    logic [DATA_W:0]   w_one;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_flag;
    logic [DATA_W:0]   w_head;

    // Gating with rst holds in_ready low throughout reset.
    assign in_ready  = rst && (r_level < LvlFull);
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign w_a   = {1'b0, data};
    assign w_b   = {1'b0, addr};
    assign w_one = {{DATA_W{1'b0}}, 1'b1};

    // One extra bit captures carry on add and borrow on subtract (wraps to 1).
    always_comb begin
        w_sum = '0;
        unique case (cmd)
            2'd0: w_sum = w_a + w_one;
            2'd1: w_sum = w_a - w_one;
            2'd2: w_sum = w_a + w_b;
            2'd3: w_sum = w_a - w_b;
            default: w_sum = '0;
        endcase
    end

    assign w_flag = w_sum[DATA_W];

    always_comb begin
        w_res = w_sum[DATA_W-1:0];
`ifdef DUT_ALU_SAT_EN
        // cmd[0] clear: INC/ADD clamp high; set: DEC/SUB clamp low.
        if (w_flag) begin
            w_res = cmd[0] ? '0 : '1;
        end
`endif
    end

    assign w_head = r_mem[r_rd];

    always_comb begin
        dout  = r_last[DATA_W-1:0];
        dflag = r_last[DATA_W];
        if (out_valid) begin
            dout  = w_head[DATA_W-1:0];
            dflag = w_head[DATA_W];
        end
    end

    // Storage needs no reset: entries are only read once level covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {w_flag, w_res};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
            r_last  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_last <= w_head;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_dut_alu_fifo.sv
// Self-checking bench for dut_alu_fifo: directed steps plus randomized traffic,
// checked against a queue-based reference model of the arithmetic and FIFO.
module tb_dut_alu_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             cmd;
    logic [DATA_W-1:0]      data;
    logic [DATA_W-1:0]      addr;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      dout;
    logic                   dflag;
    logic [$clog2(DEPTH):0] level;

    int n_checks = 0;
    int n_err    = 0;

    logic [DATA_W:0] exp_q[$];
    logic [DATA_W:0] last_out;

    dut_alu_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd       (cmd),
        .data      (data),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .dflag     (dflag),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference in plain integers: {flag, result}.
    function automatic logic [DATA_W:0] ref_op(input int c, input int a, input int b);
        int max;
        int r;
        logic f;
        logic [DATA_W-1:0] rv;
        max = 1 << DATA_W;
        case (c)
            0:       r = a + 1;
            1:       r = a - 1;
            2:       r = a + b;
            default: r = a - b;
        endcase
        f = (r >= max) || (r < 0);
`ifdef DUT_ALU_SAT_EN
        if (f) r = (r < 0) ? 0 : max - 1;
`else
        r = ((r % max) + max) % max;
`endif
        rv = r[DATA_W-1:0];
        return {f, rv};
    endfunction

    // Check visible state against the model, then advance one clock.
    task automatic tick();
        logic [DATA_W:0] head;
        logic [DATA_W:0] res;
        bit push;
        bit pop;
        head = (exp_q.size() > 0) ? exp_q[0] : last_out;
        chk("level", 32'(level), 32'(exp_q.size()));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        chk("dout", 32'(dout), 32'(head[DATA_W-1:0]));
        chk("dflag", 32'(dflag), 32'(head[DATA_W]));
        push = in_valid && (exp_q.size() < DEPTH);
        pop  = out_ready && (exp_q.size() > 0);
        res  = ref_op(int'(cmd), int'(data), int'(addr));
        @(posedge clk);
        #1;
        if (pop) last_out = exp_q.pop_front();
        if (push) exp_q.push_back(res);
    endtask

    // Single op into an empty FIFO with out_ready=1: result visible next cycle.
    task automatic op_check(input string tag, input logic [1:0] c, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] ed, input logic ef);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cmd       = c;
        data      = a;
        addr      = b;
        tick();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_dout"}, 32'(dout), 32'(ed));
        chk({tag, "_flag"}, 32'(dflag), 32'(ef));
        tick();
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("drain_bound", 32'(guard < 50), 32'd1);
    endtask

    initial begin
        int acc;
        int cyc;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cmd       = '0;
        data      = '0;
        addr      = '0;
        last_out  = '0;

        // Power-on reset state.
        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic ops.
        op_check("inc", 2'd0, 8'h05, 8'h00, 8'h06, 1'b0);
        op_check("dec", 2'd1, 8'h05, 8'h00, 8'h04, 1'b0);
        op_check("add", 2'd2, 8'h10, 8'h22, 8'h32, 1'b0);
        op_check("sub", 2'd3, 8'h22, 8'h10, 8'h12, 1'b0);

        // Boundaries.
`ifdef DUT_ALU_SAT_EN
        op_check("inc_ff", 2'd0, 8'hFF, 8'h00, 8'hFF, 1'b1);
        op_check("dec_00", 2'd1, 8'h00, 8'h00, 8'h00, 1'b1);
        op_check("add_ovf", 2'd2, 8'hF0, 8'h20, 8'hFF, 1'b1);
        op_check("sub_unf", 2'd3, 8'h10, 8'h20, 8'h00, 1'b1);
`else
        op_check("inc_ff", 2'd0, 8'hFF, 8'h00, 8'h00, 1'b1);
        op_check("dec_00", 2'd1, 8'h00, 8'h00, 8'hFF, 1'b1);
        op_check("add_ovf", 2'd2, 8'hF0, 8'h20, 8'h10, 1'b1);
        op_check("sub_unf", 2'd3, 8'h10, 8'h20, 8'hF0, 1'b1);
`endif
        // Empty FIFO holds the last popped value.
        chk("hold_empty_valid", 32'(out_valid), 32'd0);
        tick();

        // Backpressure: five INCs with out_ready low, only four fit.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            cmd      = 2'd0;
            data     = 8'(i);
            tick();
        end
        chk("bp_level", 32'(level), 32'd4);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(dout), 32'h02);
        out_ready = 1'b1;
        tick();
        // Slot freed by the pop becomes usable only now.
        chk("bp_after_pop", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        drain();
        chk("bp_last", 32'(last_out), 32'h006);

        // Concurrent push/pop at level 2.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cmd       = 2'd2;
        data      = 8'h01;
        addr      = 8'h01;
        tick();
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd  = 2'($urandom);
            data = 8'($urandom);
            addr = 8'($urandom);
            tick();
            chk("cc_level", 32'(level), 32'd2);
            chk("cc_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Reset mid-run with three queued results.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        cmd       = 2'd0;
        for (int i = 0; i < 3; i++) begin
            data = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_dout", 32'(dout), 32'd0);
        chk("mrst_dflag", 32'(dflag), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        last_out = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mrel_in_ready", 32'(in_ready), 32'd1);
        chk("mrel_valid", 32'(out_valid), 32'd0);
        chk("mrel_dout", 32'(dout), 32'd0);

        // Randomized traffic with stalls across several pointer wraps.
        acc = 0;
        cyc = 0;
        while ((acc < 3 * DEPTH || exp_q.size() > 0) && cyc < 2000) begin
            in_valid  = (acc < 3 * DEPTH) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cmd       = 2'($urandom);
            data      = 8'($urandom);
            addr      = 8'($urandom);
            if (in_valid && exp_q.size() < DEPTH) acc++;
            tick();
            cyc++;
        end
        chk("wrap_bound", 32'(cyc < 2000), 32'd1);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
